// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC hart-side claim master.
//   - DefaultClaimAddr : claim/complete register address for context 0
//   - DefaultIdW       : interrupt ID width
//   - plic_state_e     : claim FSM state encoding
package plic_pkg;

  localparam logic [23:0] DefaultClaimAddr = 24'h200004;
  localparam int unsigned DefaultIdW       = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StClaim    = 3'd1,
    StWaitRd   = 3'd2,
    StPend     = 3'd3,
    StActive   = 3'd4,
    StComplete = 3'd5
  } plic_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
//   clk_i   : clock
//   rst_ni  : async active-low reset, clears the count
//   inc_i   : increment request, ignored once the count is all-ones
//   count_o : current count
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/plic_claim_master.sv
// Hart-side claim/complete initiator for the PLIC register port (context 0).
// Claims on plic_notif & mie, presents the ID to the trap logic, and writes
// the same ID back to the claim/complete register once the handler retires.
//   clk, rstn                 : clock, async active-low reset
//   plic_notif                : PLIC has an interrupt to claim
//   plic_ren/wen/addr/wdata   : register port strobes, address and write data
//   plic_rdata                : read data, valid the cycle after plic_ren
//   mie                       : global machine interrupt enable
//   irq_pending, irq_id       : claimed interrupt presented to the core
//   trap_ack, irq_done        : trap entry / handler retirement pulses
//   busy                      : FSM not idle
//   spurious_cnt              : saturating count of empty/out-of-range claims
module plic_claim_master
  import plic_pkg::*;
#(
  parameter logic [23:0] CLAIM_ADDR = DefaultClaimAddr,
  parameter int unsigned ID_W       = DefaultIdW,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             plic_notif,
  output logic             plic_ren,
  output logic             plic_wen,
  output logic [23:0]      plic_addr,
  output logic [31:0]      plic_wdata,
  input  logic [31:0]      plic_rdata,
  input  logic             mie,
  output logic             irq_pending,
  output logic [ID_W-1:0]  irq_id,
  input  logic             trap_ack,
  input  logic             irq_done,
  output logic             busy,
  output logic [CNT_W-1:0] spurious_cnt
);

  plic_state_e      state_d, state_q;
  logic [ID_W-1:0]  irq_id_d, irq_id_q;
  logic             ren_d, ren_q;
  logic             wen_d, wen_q;
  logic [23:0]      addr_d, addr_q;
  logic [31:0]      wdata_d, wdata_q;
  logic             pending_d, pending_q;
  logic             busy_d, busy_q;
  logic             spurious;
  logic             spur_inc;

  // An ID of zero or any bit set above the ID field means nothing valid was claimed.
  always_comb begin
    spurious = (plic_rdata[ID_W-1:0] == '0) || ((plic_rdata >> ID_W) != 32'd0);
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    spur_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (plic_notif && mie) state_d = StClaim;
      end
      StClaim: state_d = StWaitRd;
      StWaitRd: begin
        if (spurious) begin
          spur_inc = 1'b1;
          state_d  = StIdle;
        end else begin
          irq_id_d = plic_rdata[ID_W-1:0];
          state_d  = StPend;
        end
      end
      StPend: begin
        // Handler may retire in the same cycle trap entry is acknowledged.
        if (trap_ack) state_d = irq_done ? StComplete : StActive;
      end
      StActive: begin
        if (irq_done) state_d = StComplete;
      end
      StComplete: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ren_d     = (state_d == StClaim);
    wen_d     = (state_d == StComplete);
    addr_d    = (ren_d || wen_d) ? CLAIM_ADDR : 24'd0;
    wdata_d   = wen_d ? {{(32-ID_W){1'b0}}, irq_id_d} : 32'd0;
    pending_d = (state_d == StPend);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      irq_id_q  <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_spurious_cnt (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .inc_i   (spur_inc),
    .count_o (spurious_cnt)
  );

  assign plic_ren    = ren_q;
  assign plic_wen    = wen_q;
  assign plic_addr   = addr_q;
  assign plic_wdata  = wdata_q;
  assign irq_pending = pending_q;
  assign irq_id      = irq_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// Randomized self-checking bench for plic_claim_master. Each claim is modelled
// as a transaction: the reference decides from the read value whether it is
// spurious, tracks the saturating spurious count, and checks the exact cycle
// at which every strobe and status output must appear.
module tb_plic_claim_master;

  localparam logic [23:0] ClaimAddr = 24'h200004;

  logic        clk;
  logic        rstn;
  logic        plic_notif;
  logic        plic_ren;
  logic        plic_wen;
  logic [23:0] plic_addr;
  logic [31:0] plic_wdata;
  logic [31:0] plic_rdata;
  logic        mie;
  logic        irq_pending;
  logic [7:0]  irq_id;
  logic        trap_ack;
  logic        irq_done;
  logic        busy;
  logic [7:0]  spurious_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  plic_claim_master #(
    .CLAIM_ADDR (ClaimAddr),
    .ID_W       (8),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .plic_notif   (plic_notif),
    .plic_ren     (plic_ren),
    .plic_wen     (plic_wen),
    .plic_addr    (plic_addr),
    .plic_wdata   (plic_wdata),
    .plic_rdata   (plic_rdata),
    .mie          (mie),
    .irq_pending  (irq_pending),
    .irq_id       (irq_id),
    .trap_ack     (trap_ack),
    .irq_done     (irq_done),
    .busy         (busy),
    .spurious_cnt (spurious_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read and write strobes must never overlap.
  always @(negedge clk) begin
    if (rstn) check_eq("ren_wen_excl", {31'd0, plic_ren & plic_wen}, 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ren"}, plic_ren, 0);
    check_eq({tag, "_wen"}, plic_wen, 0);
    check_eq({tag, "_addr"}, plic_addr, 0);
    check_eq({tag, "_wdata"}, plic_wdata, 0);
    check_eq({tag, "_pend"}, irq_pending, 0);
    check_eq({tag, "_id"}, irq_id, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_cnt"}, spurious_cnt, 0);
  endtask

  // One full claim starting from IDLE. The edge inside the first tick is the
  // sampling edge N; ren is seen in cycle N+1, rdata is driven for cycle N+2,
  // and the outcome is visible in cycle N+3.
  task automatic run_claim(input logic [31:0] rd, input int ack_gap, input int done_gap,
                           input bit both, input bit reclaim);
    bit spur;
    int id;
    id   = int'(rd % 32'd256);
    spur = (id == 0) || (rd > 32'd255);
    plic_notif = 1'b1;
    mie        = 1'b1;
    tick();
    check_eq("claim_ren", plic_ren, 1);
    check_eq("claim_addr", plic_addr, ClaimAddr);
    check_eq("claim_busy", busy, 1);
    // Notif may drop and stray pulses may arrive; none of it affects the read.
    plic_notif = 1'($urandom_range(0, 1));
    mie        = 1'($urandom_range(0, 1));
    irq_done   = 1'($urandom_range(0, 1));
    trap_ack   = 1'($urandom_range(0, 1));
    plic_rdata = $urandom;
    tick();
    check_eq("wait_ren", plic_ren, 0);
    check_eq("wait_pend", irq_pending, 0);
    plic_rdata = rd;
    plic_notif = 1'b0;
    irq_done   = 1'($urandom_range(0, 1));
    trap_ack   = 1'($urandom_range(0, 1));
    tick();
    irq_done   = 1'b0;
    trap_ack   = 1'b0;
    plic_rdata = $urandom;
    if (spur) begin
      if (exp_cnt < 255) exp_cnt++;
      check_eq("spur_pend", irq_pending, 0);
      check_eq("spur_busy", busy, 0);
      check_eq("spur_wen", plic_wen, 0);
      check_eq("spur_cnt", spurious_cnt, exp_cnt);
      return;
    end
    check_eq("pend_set", irq_pending, 1);
    check_eq("pend_id", irq_id, id);
    check_eq("pend_cnt", spurious_cnt, exp_cnt);
    for (int i = 0; i < ack_gap; i++) begin
      irq_done = 1'($urandom_range(0, 1));
      mie      = 1'($urandom_range(0, 1));
      tick();
      irq_done = 1'b0;
      check_eq("pend_hold", irq_pending, 1);
      check_eq("pend_wen", plic_wen, 0);
      check_eq("pend_id_hold", irq_id, id);
    end
    trap_ack = 1'b1;
    irq_done = both;
    tick();
    trap_ack = 1'b0;
    irq_done = 1'b0;
    check_eq("ack_pend_clr", irq_pending, 0);
    check_eq("ack_id", irq_id, id);
    if (!both) begin
      for (int i = 0; i < done_gap; i++) begin
        trap_ack = 1'($urandom_range(0, 1));
        mie      = 1'($urandom_range(0, 1));
        tick();
        trap_ack = 1'b0;
        check_eq("act_wen", plic_wen, 0);
        check_eq("act_pend", irq_pending, 0);
        check_eq("act_busy", busy, 1);
        check_eq("act_id", irq_id, id);
      end
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
    end
    check_eq("cmp_wen", plic_wen, 1);
    check_eq("cmp_wdata", plic_wdata, id);
    check_eq("cmp_addr", plic_addr, ClaimAddr);
    check_eq("cmp_id", irq_id, id);
    check_eq("cmp_ren", plic_ren, 0);
    plic_notif = reclaim;
    mie        = 1'b1;
    tick();
    check_eq("post_wen", plic_wen, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_ren", plic_ren, 0);
    check_eq("post_addr", plic_addr, 0);
  endtask

  initial begin
    logic [31:0] rd;
    rstn       = 1'b0;
    plic_notif = 1'b0;
    plic_rdata = 32'd0;
    mie        = 1'b0;
    trap_ack   = 1'b0;
    irq_done   = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();
    check_reset_outputs("idle");

    // Spurious claims: zero ID, then a value above the ID field.
    run_claim(32'h0000_0000, 0, 0, 1'b0, 1'b0);
    run_claim(32'h0000_0100, 0, 0, 1'b0, 1'b0);
    check_eq("spur_two", spurious_cnt, 2);

    // Basic flow with ID 5, then earliest re-claim two cycles after the write.
    run_claim(32'd5, 1, 2, 1'b0, 1'b1);
    run_claim(32'd0, 0, 0, 1'b0, 1'b0);

    // Masked notification never claims.
    plic_notif = 1'b1;
    mie        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("mask_ren", plic_ren, 0);
      check_eq("mask_busy", busy, 0);
    end
    run_claim(32'd17, 0, 0, 1'b0, 1'b0);

    // Trap entry and retirement together: ACTIVE is skipped.
    run_claim(32'd127, 2, 0, 1'b1, 1'b0);

    // Randomized transactions with idle gaps and stray pulses.
    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        plic_notif = 1'($urandom_range(0, 1));
        mie        = plic_notif ? 1'b0 : 1'($urandom_range(0, 1));
        trap_ack   = 1'($urandom_range(0, 1));
        irq_done   = 1'($urandom_range(0, 1));
        tick();
        trap_ack   = 1'b0;
        irq_done   = 1'b0;
        check_eq("gap_busy", busy, 0);
        check_eq("gap_ren", plic_ren, 0);
        check_eq("gap_wen", plic_wen, 0);
        check_eq("gap_pend", irq_pending, 0);
      end
      plic_notif = 1'b0;
      case ($urandom_range(0, 9))
        0:       rd = 32'd0;
        1:       rd = $urandom | 32'h0000_0100;
        default: rd = 32'($urandom_range(1, 127));
      endcase
      run_claim(rd, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3) == 0,
                1'b0);
    end

    // Reset while ACTIVE with ID 9: outputs clear asynchronously, no complete write.
    if (exp_cnt == 0) run_claim(32'd0, 0, 0, 1'b0, 1'b0);
    plic_notif = 1'b1;
    mie        = 1'b1;
    tick();
    plic_notif = 1'b0;
    tick();
    plic_rdata = 32'd9;
    tick();
    check_eq("rst_pre_id", irq_id, 9);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check_eq("rst_pre_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    exp_cnt = 0;
    check_reset_outputs("async_rst");
    tick();
    rstn     = 1'b1;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_post_wen", plic_wen, 0);
      check_eq("rst_post_busy", busy, 0);
      tick();
    end

    // Saturation of the spurious counter.
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom | 32'h0000_0100);
      run_claim(rd, 0, 0, 1'b0, 1'b0);
    end
    check_eq("sat_cnt", spurious_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
